// File: rtl/sw_pkg.sv
// sw_pkg: shared FSM states, header layout and tail-mask helper for the sequence loader
package sw_pkg;
   typedef enum logic [1:0] {IDLE, REF, READ, OUT} state_t;
   localparam int BASES_PER_WORD = 16;
   localparam int HDR_REF_MSB = 31;
   localparam int HDR_REF_LSB = 16;
   localparam int HDR_READ_MSB = 15;
   localparam int HDR_READ_LSB = 0;
   function automatic logic [31:0] base_mask(input logic [3:0] len_mod16);
      return (len_mod16 == 4'd0) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> {len_mod16, 1'b0});
   endfunction
endpackage

// File: rtl/sw_seq_loader_if.sv
// sw_seq_loader_if: word stream in, job bus out to the Smith-Waterman core
interface sw_seq_loader_if #(
   parameter int REF_MAX_LENGTH = 128,
   parameter int READ_MAX_LENGTH = 128
);
   logic                                   i_word_valid;
   logic                                   o_word_ready;
   logic [31:0]                            i_word_data;
   logic                                   o_valid;
   logic                                   i_ready;
   logic [2*REF_MAX_LENGTH-1:0]            o_sequence_ref;
   logic [2*READ_MAX_LENGTH-1:0]           o_sequence_read;
   logic [$clog2(REF_MAX_LENGTH):0]        o_seq_ref_length;
   logic [$clog2(READ_MAX_LENGTH):0]       o_seq_read_length;
   logic                                   o_error;
   modport slave (
      input  i_word_valid, i_word_data, i_ready,
      output o_word_ready, o_valid, o_sequence_ref, o_sequence_read,
             o_seq_ref_length, o_seq_read_length, o_error
   );
   modport master (
      output i_word_valid, i_word_data, i_ready,
      input  o_word_ready, o_valid, o_sequence_ref, o_sequence_read,
             o_seq_ref_length, o_seq_read_length, o_error
   );
endinterface

// File: rtl/sw_word_placer.sv
// sw_word_placer: writes a masked 32-bit word at word slot k (MSB-first) of a wide buffer
module sw_word_placer #(
   parameter int W  = 256,
   parameter int IW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          wr_i,
   input  logic [IW-1:0] idx_i,
   input  logic [31:0]   data_i,
   input  logic [31:0]   keep_i,
   output logic [W-1:0]  buf_o
);
   logic [W-1:0] buf_q;
   // buffer: cleared by a new header, otherwise one slot written per accepted word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) buf_q <= '0;
      else if (clr_i) buf_q <= '0;
      else if (wr_i)
         for (int k = 0; k < W/32; k++)
            if (idx_i == IW'(k)) buf_q[W-1-32*k -: 32] <= data_i & keep_i;
   end
   assign buf_o = buf_q;
endmodule

// File: rtl/sw_seq_loader.sv
// sw_seq_loader: parses header + packed bases from a word stream into one core job
module sw_seq_loader
   import sw_pkg::*;
#(
   parameter int REF_MAX_LENGTH = 128,
   parameter int READ_MAX_LENGTH = 128
) (
   input logic              clk,
   input logic              rst_n,
   sw_seq_loader_if.slave   bus
);
   localparam int RLW = $clog2(REF_MAX_LENGTH) + 1;
   localparam int DLW = $clog2(READ_MAX_LENGTH) + 1;
   localparam int CW  = (RLW > DLW) ? RLW : DLW;
   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [RLW-1:0] ref_len_q, ref_len_d;
   logic [DLW-1:0] read_len_q, read_len_d;
   logic           err_q, err_d;
   logic [15:0]    hdr_ref, hdr_read;
   logic           hdr_ok, accept, clr, wr_ref, wr_read, last_ref, last_read;
   logic [CW-1:0]  ref_words, read_words;
   logic [31:0]    keep_ref, keep_read;

   assign hdr_ref    = bus.i_word_data[HDR_REF_MSB:HDR_REF_LSB];
   assign hdr_read   = bus.i_word_data[HDR_READ_MSB:HDR_READ_LSB];
   assign hdr_ok     = hdr_ref != 16'd0 && hdr_ref <= 16'(REF_MAX_LENGTH) &&
                       hdr_read != 16'd0 && hdr_read <= 16'(READ_MAX_LENGTH);
   assign accept     = bus.i_word_valid && bus.o_word_ready;
   assign ref_words  = CW'((ref_len_q + RLW'(BASES_PER_WORD-1)) / RLW'(BASES_PER_WORD));
   assign read_words = CW'((read_len_q + DLW'(BASES_PER_WORD-1)) / DLW'(BASES_PER_WORD));
   assign last_ref   = cnt_q == ref_words - CW'(1);
   assign last_read  = cnt_q == read_words - CW'(1);
   // only the final word of a sequence can hold bases beyond its length
   assign keep_ref   = last_ref ? base_mask(ref_len_q[3:0]) : 32'hFFFF_FFFF;
   assign keep_read  = last_read ? base_mask(read_len_q[3:0]) : 32'hFFFF_FFFF;

   assign bus.o_word_ready      = state_q != OUT;
   assign bus.o_valid           = state_q == OUT;
   assign bus.o_error           = err_q;
   assign bus.o_seq_ref_length  = ref_len_q;
   assign bus.o_seq_read_length = read_len_q;

   // next state: header check in IDLE, word counting through REF/READ, hold job in OUT
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ref_len_d  = ref_len_q;
      read_len_d = read_len_q;
      err_d      = 1'b0;
      clr        = 1'b0;
      wr_ref     = 1'b0;
      wr_read    = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            if (hdr_ok) begin
               state_d    = REF;
               cnt_d      = '0;
               ref_len_d  = RLW'(hdr_ref);
               read_len_d = DLW'(hdr_read);
               clr        = 1'b1;
            end else err_d = 1'b1;
         end
         REF: if (accept) begin
            wr_ref  = 1'b1;
            cnt_d   = last_ref ? '0 : cnt_q + CW'(1);
            state_d = last_ref ? READ : REF;
         end
         READ: if (accept) begin
            wr_read = 1'b1;
            cnt_d   = last_read ? '0 : cnt_q + CW'(1);
            state_d = last_read ? OUT : READ;
         end
         OUT: state_d = bus.i_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
   end

   // state, counter, lengths and error pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ref_len_q  <= '0;
         read_len_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ref_len_q  <= ref_len_d;
         read_len_q <= read_len_d;
         err_q      <= err_d;
      end
   end

   sw_word_placer #(.W(2*REF_MAX_LENGTH), .IW(CW)) u_ref (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .wr_i(wr_ref), .idx_i(cnt_q),
      .data_i(bus.i_word_data), .keep_i(keep_ref), .buf_o(bus.o_sequence_ref)
   );

   sw_word_placer #(.W(2*READ_MAX_LENGTH), .IW(CW)) u_read (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .wr_i(wr_read), .idx_i(cnt_q),
      .data_i(bus.i_word_data), .keep_i(keep_read), .buf_o(bus.o_sequence_read)
   );
endmodule

// File: tb/tb_sw_seq_loader.sv
// tb_sw_seq_loader: directed jobs checked against a base-level model of the packed buses
module tb_sw_seq_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sw_seq_loader_if #(.REF_MAX_LENGTH(128), .READ_MAX_LENGTH(128)) bus ();
   sw_seq_loader #(.REF_MAX_LENGTH(128), .READ_MAX_LENGTH(128)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   int err_seen = 0;
   int err_exp = 0;
   int hs_seen = 0;
   bit pend = 1'b0;
   logic [31:0]  rw [8];
   logic [31:0]  dw [8];
   logic [255:0] exp_ref, exp_read;
   logic [7:0]   exp_rl, exp_dl;

   task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   // base i of a sequence lands at bus bits [255-2i -: 2]; bases past len are zero
   function automatic logic [255:0] model_bus(input int len, input bit is_read);
      logic [255:0] e;
      logic [31:0] w;
      e = '0;
      for (int i = 0; i < len; i++) begin
         w = is_read ? dw[i/16] : rw[i/16];
         e[255-2*i -: 2] = w[31-2*(i%16) -: 2];
      end
      return e;
   endfunction

   // per-cycle comparison of the job bus against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready_vs_valid", bus.o_word_ready, !bus.o_valid);
         chk("valid_vs_model", bus.o_valid, pend);
         if (bus.o_valid) begin
            chk("seq_ref", bus.o_sequence_ref, exp_ref);
            chk("seq_read", bus.o_sequence_read, exp_read);
            chk("ref_len", bus.o_seq_ref_length, exp_rl);
            chk("read_len", bus.o_seq_read_length, exp_dl);
         end
         if (bus.o_error) err_seen++;
         if (bus.o_valid && bus.i_ready) begin
            hs_seen++;
            pend = 1'b0;
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input int gap);
      int t;
      bus.i_word_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.i_word_data  = d;
      bus.i_word_valid = 1'b1;
      t = 0;
      while (!bus.o_word_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (t == 50) chk("word_ready_timeout", 0, 1);
      @(posedge clk); #1;
      bus.i_word_valid = 1'b0;
   endtask

   task automatic send_job(input logic [31:0] hdr, input int maxgap);
      int rl, dl;
      rl = int'(hdr[31:16]);
      dl = int'(hdr[15:0]);
      exp_ref  = model_bus(rl, 1'b0);
      exp_read = model_bus(dl, 1'b1);
      exp_rl   = 8'(rl);
      exp_dl   = 8'(dl);
      send_word(hdr, 0);
      for (int k = 0; k < (rl + 15) / 16; k++) send_word(rw[k], $urandom_range(0, maxgap));
      for (int k = 0; k < (dl + 15) / 16; k++) send_word(dw[k], $urandom_range(0, maxgap));
      pend = 1'b1;
      chk("latency_valid", bus.o_valid, 1);
   endtask

   task automatic do_reset();
      pend = 1'b0;
      bus.i_word_valid = 1'b0;
      bus.i_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_ref", bus.o_sequence_ref, 0);
      chk("rst_read", bus.o_sequence_read, 0);
      chk("rst_ref_len", bus.o_seq_ref_length, 0);
      chk("rst_read_len", bus.o_seq_read_length, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_error", bus.o_error, 0);
      chk("rst_ready", bus.o_word_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic expect_done();
      @(posedge clk); #1;
      chk("post_hs_valid", bus.o_valid, 0);
      chk("post_hs_ready", bus.o_word_ready, 1);
   endtask

   task automatic bad_header(input logic [31:0] hdr);
      send_word(hdr, 0);
      err_exp++;
      chk("err_pulse", bus.o_error, 1);
      @(posedge clk); #1;
      chk("err_fall", bus.o_error, 0);
      chk("err_no_valid", bus.o_valid, 0);
   endtask

   initial begin
      int hs0;
      bus.i_word_valid = 1'b0;
      bus.i_word_data  = '0;
      bus.i_ready      = 1'b0;
      @(posedge clk); #1;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         rw[k] = 32'h0123_4567 + 32'(k) * 32'h1111_1111;
         dw[k] = ~rw[k] ^ 32'(k * 7);
      end
      bus.i_ready = 1'b1;
      send_job(32'h0080_0080, 0);
      chk("model_full_ref", exp_ref, {rw[0], rw[1], rw[2], rw[3], rw[4], rw[5], rw[6], rw[7]});
      @(negedge clk);
      chk("full_ref_lit", bus.o_sequence_ref, {rw[0], rw[1], rw[2], rw[3], rw[4], rw[5], rw[6], rw[7]});
      chk("full_read_lit", bus.o_sequence_read, {dw[0], dw[1], dw[2], dw[3], dw[4], dw[5], dw[6], dw[7]});
      chk("full_len", {bus.o_seq_ref_length, bus.o_seq_read_length}, 16'h8080);
      expect_done();
      chk("full_hs", hs_seen, 1);

      rw[0] = '1; rw[1] = '1; dw[0] = '1;
      send_job(32'h0014_0005, 0);
      chk("model_short_read", exp_read, {10'h3FF, 246'h0});
      @(negedge clk);
      chk("short_ref_lit", bus.o_sequence_ref, {40'hFF_FFFF_FFFF, 216'h0});
      chk("short_read_lit", bus.o_sequence_read, {10'h3FF, 246'h0});
      chk("short_len", {bus.o_seq_ref_length, bus.o_seq_read_length}, 16'h1405);
      expect_done();

      for (int k = 0; k < 8; k++) begin
         rw[k] = 32'hA5C3_0F96 ^ (32'(k) << (3 * k));
         dw[k] = 32'h5A3C_F069 + 32'(k * 1234567);
      end
      bus.i_ready = 1'b0;
      send_job(32'h0025_0031, 0);
      for (int c = 0; c < 10; c++) begin
         bus.i_word_valid = 1'b1;
         bus.i_word_data  = 32'h0001_0001;
         @(posedge clk); #1;
         chk("bp_ready_low", bus.o_word_ready, 0);
         chk("bp_valid_high", bus.o_valid, 1);
      end
      bus.i_word_valid = 1'b0;
      hs0 = hs_seen;
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("bp_one_transfer", hs_seen, hs0 + 1);
      chk("bp_valid_low", bus.o_valid, 0);

      bad_header(32'h0000_0010);
      bad_header(32'h0081_0010);
      bad_header(32'h0010_0000);
      bus.i_ready = 1'b1;
      send_job(32'h0010_0011, 0);
      expect_done();
      chk("err_count", err_seen, err_exp);

      for (int k = 0; k < 8; k++) begin
         rw[k] = 32'h0123_4567 + 32'(k) * 32'h1111_1111;
         dw[k] = ~rw[k] ^ 32'(k * 7);
      end
      send_job(32'h0080_0080, 3);
      @(negedge clk);
      chk("gap_ref_lit", bus.o_sequence_ref, {rw[0], rw[1], rw[2], rw[3], rw[4], rw[5], rw[6], rw[7]});
      expect_done();

      send_word(32'h0080_0080, 0);
      for (int k = 0; k < 3; k++) send_word(32'hFFFF_FFFF, 0);
      do_reset();
      for (int k = 0; k < 8; k++) begin
         rw[k] = 32'h1357_9BDF ^ 32'(k);
         dw[k] = 32'hECA8_6420 ^ 32'(k << 8);
      end
      bus.i_ready = 1'b1;
      send_job(32'h0030_0020, 1);
      @(negedge clk);
      chk("rst_job_ref_lit", bus.o_sequence_ref, {rw[0], rw[1], rw[2], 160'h0});
      expect_done();
      chk("hs_total", hs_seen, 6);
      chk("err_total", err_seen, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sw_seq_loader.md
# sw_seq_loader

Upstream feeder for the Smith-Waterman core (`SW_core`). It accepts a 32-bit word stream carrying one header word followed by packed 2-bit-per-base reference and read sequences. It assembles them into the core's wide, MSB-aligned, zero-padded sequence buses and presents one job per valid/ready handshake on the core's input port.

## Interface
- `REF_MAX_LENGTH`, 128: max reference bases; must be a multiple of 16.
- `READ_MAX_LENGTH`, 128: max read bases; must be a multiple of 16.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_word_valid`  in  1  stream word valid.
- `o_word_ready`  out  1  loader can accept a stream word.
- `i_word_data`  in  32  stream word (header or 16 packed bases, base 0 in [31:30]).
- `o_valid`  out  1  job valid; connects to core `i_valid`.
- `i_ready`  in  1  core ready; connects from core `o_ready`.
- `o_sequence_ref`  out  2*REF_MAX_LENGTH  reference bases, MSB-first, zero-padded.
- `o_sequence_read`  out  2*READ_MAX_LENGTH  read bases, MSB-first, zero-padded.
- `o_seq_ref_length`  out  $clog2(REF_MAX_LENGTH)+1  reference length, 1-based.
- `o_seq_read_length`  out  $clog2(READ_MAX_LENGTH)+1  read length, 1-based.
- `o_error`  out  1  one-cycle pulse when a header is rejected.

## Operation
- Header word: [31:16] = ref_len, [15:0] = read_len. It is valid iff 1 ≤ ref_len ≤ REF_MAX_LENGTH and 1 ≤ read_len ≤ READ_MAX_LENGTH.
- Word counts: ref_words = ceil(ref_len/16) and read_words = ceil(read_len/16), computed at header acceptance.
- States:
  - IDLE: wait for the header.
    - Valid header: latch the lengths, clear both sequence buffers to 0, go to REF.
    - Invalid header: pulse `o_error` the next cycle and stay in IDLE. No payload is consumed; subsequent words are parsed as headers.
  - REF: payload word k (0-based) is written to `o_sequence_ref[2*REF_MAX_LENGTH-1-32k -: 32]`. After word ref_words-1 is accepted, go to READ.
  - READ: same placement rule into `o_sequence_read`. After word read_words-1 is accepted, go to OUT.
  - OUT: `o_valid`=1. When `o_valid & i_ready`, go to IDLE.
- Tail masking: in the last word of each sequence, bases at index ≥ (len mod 16) are forced to 0. This applies only when len mod 16 ≠ 0.
- A word is accepted only in a cycle where `i_word_valid & o_word_ready`. Gaps with `i_word_valid`=0 simply stall the counters.
- `o_word_ready` = 1 in IDLE, REF and READ; 0 in OUT. There is no overlap between jobs.
- Sequence and length outputs are registers that are stable from `o_valid` rise until the handshake. They are not cleared after the handshake; the next header clears them.

## Timing
- Reset values while `rst_n`=0 (asynchronous):
  - state IDLE, so `o_word_ready`=1 (combinational from state);
  - `o_valid`=0, `o_error`=0;
  - all sequence and length outputs 0;
  - word counter 0.
- Latency: the last read word is accepted at edge N, and `o_valid`=1 after edge N (registered).
- Handshake: the core samples at the edge where `o_valid & i_ready`. `o_valid` falls after that edge. `o_word_ready` rises the same cycle, combinationally from IDLE.
- `o_error` rises the cycle after the rejecting edge and lasts exactly one cycle.
- Minimum job time: 1 + ref_words + read_words accepted words, plus 1 cycle to the OUT state, plus 1 handshake cycle.
- Mid-packet reset: everything returns to the reset values immediately. Partial data is discarded, and the next word after reset is parsed as a header.
- `i_ready` is ignored outside OUT. `i_word_valid` is ignored in OUT.

## Structure
- The shared package `sw_pkg` holds:
  - the state enum (IDLE, REF, READ, OUT);
  - the header field positions;
  - BASES_PER_WORD=16;
  - the tail-mask function `base_mask(len_mod16)`, which returns a 32-bit keep-mask.
- Length widths derive from the existing REF/READ max-length settings shared with `SW_core`.
- One sub-module is natural: `sw_word_placer`. It is parameterised by buffer width, writes a masked 32-bit word at word index k into a wide register, and is instantiated once for ref and once for read.
- The FSM, counters and header check stay in `sw_seq_loader`.

## Test plan
- Full job: header 0x0080_0080, 8 ref words + 8 read words, `i_ready`=1 → `o_valid` one cycle after the last word. Buses equal the concatenated words, lengths are 128/128, the handshake completes in one cycle, and `o_word_ready` returns to 1.
- Short/masked: header 0x0014_0005, ref 2 words all 0xFFFF_FFFF, read 1 word 0xFFFF_FFFF → `o_sequence_ref[255:216]` all ones and the rest 0; `o_sequence_read[255:246]` all ones and the rest 0.
- Backpressure: hold `i_ready`=0 for 10 cycles in OUT → `o_valid` and data stay stable and `o_word_ready`=0 throughout. Raise `i_ready` → exactly one transfer.
- Invalid headers: 0x0000_0010 and then 0x0081_0010 → two `o_error` pulses, `o_valid` never rises, and a following valid job completes correctly.
- Stream gaps: random `i_word_valid` deasserts within the payload → result is identical to the gap-free run.
- Reset mid-payload: assert `rst_n`=0 after 3 ref words → all outputs return to their reset values. The next valid job produces correct buses with no residue from the aborted job.
